// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch controller slice: controller state encoding and time word width.
package stopwatch_pkg;

  localparam int TIME_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a debounced button level; history resets to 1 so a button
// held through reset does not produce an event.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/lap_display_ctrl.sv
// Stopwatch run/pause/lap controller: sequences the time counter and selects live or lap time
// for the display mux. Optional lap auto-return after HOLD_TICKS ticks under `LAP_TIMEOUT_EN.
module lap_display_ctrl
  import stopwatch_pkg::*;
#(
  parameter int W          = TIME_W,
  parameter int HOLD_TICKS = 300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_start,
  input  logic         btn_lap,
  input  logic         btn_clr,
  input  logic         tick,
  input  logic [W-1:0] live_time,
  output logic         count_en,
  output logic         count_clr,
  output logic [W-1:0] lap_time,
  output logic         disp_sel
);

  state_t state_q, state_d;
  logic   start_ev, lap_ev, clr_ev;
  logic   clr_fire, lap_capture, timeout;

  edge_det u_start (.clk(clk), .rst(rst), .din(btn_start), .rise(start_ev));
  edge_det u_lap   (.clk(clk), .rst(rst), .din(btn_lap),   .rise(lap_ev));
  edge_det u_clr   (.clk(clk), .rst(rst), .din(btn_clr),   .rise(clr_ev));

`ifdef LAP_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  logic [HOLD_W-1:0] hold_cnt;

  assign timeout = (state_q == LAP) && tick && (hold_cnt == HOLD_LAST);

  // Counts only while LAP persists; any exit or fresh entry starts again from zero.
  always_ff @(posedge clk) begin
    if (rst)                                    hold_cnt <= '0;
    else if (state_q != LAP || state_d != LAP)  hold_cnt <= '0;
    else if (tick)                              hold_cnt <= hold_cnt + 1'b1;
  end
`else
  logic unused_tick;
  assign unused_tick = tick ^ (HOLD_TICKS != 0);
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    clr_fire    = 1'b0;
    lap_capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_ev)        clr_fire = 1'b1;
        else if (start_ev) state_d  = RUN;
      end
      RUN: begin
        if (start_ev) state_d = PAUSE;
        else if (lap_ev) begin
          state_d     = LAP;
          lap_capture = 1'b1;
        end
      end
      LAP: begin
        if (start_ev)              state_d = PAUSE;
        else if (lap_ev || timeout) state_d = RUN;
      end
      PAUSE: begin
        if (clr_ev) begin
          state_d  = IDLE;
          clr_fire = 1'b1;
        end else if (start_ev) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_en = (state_q == RUN) || (state_q == LAP);
    disp_sel = (state_q == LAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_clr <= 1'b0;
      lap_time  <= '0;
    end else begin
      count_clr <= clr_fire;
      if (clr_fire)         lap_time <= '0;
      else if (lap_capture) lap_time <= live_time;
    end
  end

endmodule

// File: tb/tb_lap_display_ctrl.sv
// Directed self-checking bench for lap_display_ctrl; expected values are hand-derived per step.
module tb_lap_display_ctrl;
  import stopwatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, btn_start, btn_lap, btn_clr, tick;
  logic [15:0] live_time;
  logic        count_en, count_clr, disp_sel;
  logic [15:0] lap_time;

  int checks = 0;
  int errors = 0;

  lap_display_ctrl #(.W(16), .HOLD_TICKS(3)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .tick(tick), .live_time(live_time), .count_en(count_en), .count_clr(count_clr),
    .lap_time(lap_time), .disp_sel(disp_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic l, input logic c);
    btn_start = s;
    btn_lap   = l;
    btn_clr   = c;
    cyc();
  endtask

  task automatic release_btns();
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clr   = 1'b0;
    cyc();
  endtask

  task automatic check_outs(input string tag, input state_t st, input logic en, input logic clr,
                            input logic sel, input logic [15:0] lap);
    check({tag, ".state"}, 32'(dut.state_q), 32'(st));
    check({tag, ".count_en"}, 32'(count_en), 32'(en));
    check({tag, ".count_clr"}, 32'(count_clr), 32'(clr));
    check({tag, ".disp_sel"}, 32'(disp_sel), 32'(sel));
    check({tag, ".lap_time"}, 32'(lap_time), 32'(lap));
  endtask

  initial begin
    rst = 1'b1; btn_start = 1'b1; btn_lap = 1'b0; btn_clr = 1'b0; tick = 1'b0;
    live_time = 16'h0000;
    cyc(); cyc();
    rst = 1'b0;
    cyc(); cyc();
    check_outs("reset_held_start", IDLE, 1'b0, 1'b0, 1'b0, 16'h0000);
    release_btns();
    check_outs("idle_after_release", IDLE, 1'b0, 1'b0, 1'b0, 16'h0000);

    // start held for 10 cycles: exactly one toggle into RUN
    press(1'b1, 1'b0, 1'b0);
    check_outs("start_edge", RUN, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 9; i++) cyc();
    check_outs("start_held", RUN, 1'b1, 1'b0, 1'b0, 16'h0000);
    release_btns();

    press(1'b1, 1'b0, 1'b0);
    check_outs("pause", PAUSE, 1'b0, 1'b0, 1'b0, 16'h0000);
    release_btns();
    press(1'b1, 1'b0, 1'b0);
    check_outs("resume", RUN, 1'b1, 1'b0, 1'b0, 16'h0000);
    release_btns();

    live_time = 16'h0123;
    press(1'b0, 1'b1, 1'b0);
    live_time = 16'h0456;
    check_outs("lap_capture", LAP, 1'b1, 1'b0, 1'b1, 16'h0123);
    release_btns();
    check_outs("lap_hold", LAP, 1'b1, 1'b0, 1'b1, 16'h0123);

    press(1'b0, 1'b0, 1'b1);
    check_outs("clr_in_lap", LAP, 1'b1, 1'b0, 1'b1, 16'h0123);
    release_btns();

    press(1'b0, 1'b1, 1'b0);
    check_outs("lap_release", RUN, 1'b1, 1'b0, 1'b0, 16'h0123);
    release_btns();
    press(1'b0, 1'b0, 1'b1);
    check_outs("clr_in_run", RUN, 1'b1, 1'b0, 1'b0, 16'h0123);
    release_btns();

    press(1'b1, 1'b0, 1'b0);
    check_outs("pause2", PAUSE, 1'b0, 1'b0, 1'b0, 16'h0123);
    release_btns();
    press(1'b1, 1'b0, 1'b1);
    check_outs("clr_start_pause", IDLE, 1'b0, 1'b1, 1'b0, 16'h0000);
    release_btns();
    check_outs("clr_pulse_end", IDLE, 1'b0, 1'b0, 1'b0, 16'h0000);

    // wrapped counter value is captured verbatim
    press(1'b1, 1'b0, 1'b0);
    release_btns();
    live_time = 16'hFFFF;
    press(1'b0, 1'b1, 1'b0);
    check_outs("lap_wrap", LAP, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    release_btns();

`ifdef LAP_TIMEOUT_EN
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    check_outs("timeout_2ticks", LAP, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    tick = 1'b1; cyc(); tick = 1'b0;
    check_outs("timeout_3rd", RUN, 1'b1, 1'b0, 1'b0, 16'hFFFF);

    live_time = 16'h0042;
    press(1'b0, 1'b1, 1'b0);
    release_btns();
    check_outs("relap", LAP, 1'b1, 1'b0, 1'b1, 16'h0042);
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    tick = 1'b1;
    press(1'b0, 1'b1, 1'b0);
    tick = 1'b0;
    check_outs("lap_with_timeout", RUN, 1'b1, 1'b0, 1'b0, 16'h0042);
    release_btns();
    check_outs("no_double", RUN, 1'b1, 1'b0, 1'b0, 16'h0042);
    live_time = 16'h0777;
    press(1'b0, 1'b1, 1'b0);
    release_btns();
    check_outs("lap_again", LAP, 1'b1, 1'b0, 1'b1, 16'h0777);
`else
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    check_outs("lap_persists", LAP, 1'b1, 1'b0, 1'b1, 16'hFFFF);
`endif

    rst = 1'b1;
    cyc();
    check_outs("reset_in_lap", IDLE, 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    cyc();
    check_outs("after_reset", IDLE, 1'b0, 1'b0, 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
